// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and default widths for sequence generators/detectors
package seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } seq_state_t;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP_W = 4;

endpackage

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial MSB-first pattern transmitter with repeat count and idle gap
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_count,
  input  logic [GAP_W-1:0] gap,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  seq_state_t       state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0] rep_left, rep_left_n, rep_dec;
  logic [GAP_W-1:0] gap_len, gap_len_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             seq_valid_n, busy_n, done_n;

  // The shift register is cleared outside SHIFT, so its MSB is the serial output directly.
  assign seq_out = shreg[PAT_W-1];
  assign rep_dec = rep_left - CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      pat_q     <= '0;
      bit_cnt   <= '0;
      rep_left  <= '0;
      gap_len   <= '0;
      gap_cnt   <= '0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      pat_q     <= pat_n;
      bit_cnt   <= bit_cnt_n;
      rep_left  <= rep_left_n;
      gap_len   <= gap_len_n;
      gap_cnt   <= gap_cnt_n;
      seq_valid <= seq_valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    pat_n       = pat_q;
    bit_cnt_n   = bit_cnt;
    rep_left_n  = rep_left;
    gap_len_n   = gap_len;
    gap_cnt_n   = gap_cnt;
    seq_valid_n = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SHIFT;
          shreg_n     = pattern;
          pat_n       = pattern;
          bit_cnt_n   = '0;
          rep_left_n  = (repeat_count == '0) ? CNT_W'(1) : repeat_count;
          gap_len_n   = gap;
          seq_valid_n = 1'b1;
          busy_n      = 1'b1;
        end
      end

      SHIFT: begin
        busy_n = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          rep_left_n = rep_dec;
          bit_cnt_n  = '0;
          if (rep_dec == '0) begin
            state_n = DONE;
            shreg_n = '0;
            done_n  = 1'b1;
          end else if (gap_len == '0) begin
            shreg_n     = pat_q;
            seq_valid_n = 1'b1;
          end else begin
            state_n   = GAP;
            shreg_n   = '0;
            gap_cnt_n = gap_len;
          end
        end else begin
          shreg_n     = {shreg[PAT_W-2:0], 1'b0};
          bit_cnt_n   = bit_cnt + BIT_W'(1);
          seq_valid_n = 1'b1;
        end
      end

      GAP: begin
        busy_n    = 1'b1;
        gap_cnt_n = gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) begin
          state_n     = SHIFT;
          shreg_n     = pat_q;
          bit_cnt_n   = '0;
          seq_valid_n = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end
    endcase

    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_n     = IDLE;
      shreg_n     = '0;
      pat_n       = '0;
      bit_cnt_n   = '0;
      rep_left_n  = '0;
      gap_len_n   = '0;
      gap_cnt_n   = '0;
      seq_valid_n = 1'b0;
      busy_n      = 1'b0;
      done_n      = 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - randomized self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [3:0] repeat_count;
  logic [3:0] gap;
  logic       seq_out;
  logic       seq_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [3:0] hist = '0;
  int det_hits = 0;
  int busy_cycles = 0;
  int done_hits = 0;

  always #5 clock = ~clock;

  seq_pattern_gen dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .abort(abort),
    .pattern(pattern),
    .repeat_count(repeat_count),
    .gap(gap),
    .seq_out(seq_out),
    .seq_valid(seq_valid),
    .busy(busy),
    .done(done)
  );

  // Behavioural 1011 overlapping detector plus activity counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (seq_valid) begin
      if ({hist[2:0], seq_out} == 4'b1011) det_hits++;
      hist = {hist[2:0], seq_out};
    end
    if (busy) busy_cycles++;
    if (done) done_hits++;
  end

  // Reference: expected per-cycle (valid, bit, busy, done) list built from the pattern rules.
  task automatic run_tx(input logic [3:0] pat, input int rep, input int gp, input bit noisy,
                        input string name);
    int r;
    bit ev[$];
    bit eb[$];
    bit ey[$];
    bit ed[$];
    logic [3:0] rq;
    logic [3:0] gq;
    r = (rep == 0) ? 1 : rep;
    for (int k = 0; k < r; k++) begin
      for (int i = PAT_W - 1; i >= 0; i--) begin
        ev.push_back(1'b1); eb.push_back(pat[i]); ey.push_back(1'b1); ed.push_back(1'b0);
      end
      if (k < r - 1)
        for (int g = 0; g < gp; g++) begin
          ev.push_back(1'b0); eb.push_back(1'b0); ey.push_back(1'b1); ed.push_back(1'b0);
        end
    end
    ev.push_back(1'b0); eb.push_back(1'b0); ey.push_back(1'b1); ed.push_back(1'b1);
    ev.push_back(1'b0); eb.push_back(1'b0); ey.push_back(1'b0); ed.push_back(1'b0);
    rq = rep[3:0];
    gq = gp[3:0];
    @(negedge clock);
    pattern = pat; repeat_count = rq; gap = gq; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int j = 0; j < ev.size(); j++) begin
      checks++;
      if ({seq_valid, seq_out, busy, done} !== {ev[j], eb[j], ey[j], ed[j]}) begin
        errors++;
        $display("FAIL %s cycle %0d: valid/out/busy/done got %b%b%b%b expected %b%b%b%b",
                 name, j, seq_valid, seq_out, busy, done, ev[j], eb[j], ey[j], ed[j]);
      end
      if (noisy && j < ev.size() - 2) begin
        start = 1'($urandom_range(0, 1));
        pattern = 4'($urandom);
        repeat_count = 4'($urandom);
        gap = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (j < ev.size() - 1) begin
        @(posedge clock); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; repeat_count = '0; gap = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({seq_out, seq_valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset: out/valid/busy/done got %b%b%b%b expected 0000",
               seq_out, seq_valid, busy, done);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    run_tx(4'b1011, 1, 0, 1'b0, "single_1011");
  endtask

  task automatic test_back_to_back();
    hist = '0; det_hits = 0;
    run_tx(4'b1011, 2, 0, 1'b0, "contig_1011x2");
    checks++;
    if (det_hits !== 2) begin
      errors++;
      $display("FAIL detector_hits: got %0d expected 2", det_hits);
    end
  endtask

  task automatic test_gap();
    @(negedge clock);
    busy_cycles = 0;
    run_tx(4'b1010, 3, 2, 1'b0, "gap_1010x3");
    checks++;
    if (busy_cycles !== 17) begin
      errors++;
      $display("FAIL busy_cycles: got %0d expected 17", busy_cycles);
    end
  endtask

  task automatic test_repeat_zero();
    run_tx(4'b0110, 0, 3, 1'b0, "repeat_zero_0110");
  endtask

  task automatic test_start_ignored();
    done_hits = 0;
    run_tx(4'b1101, 2, 1, 1'b1, "restart_ignored");
    repeat (4) begin
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || seq_valid !== 1'b0) begin
        errors++;
        $display("FAIL no_second_tx: busy/valid got %b%b expected 00", busy, seq_valid);
      end
    end
    checks++;
    if (done_hits !== 1) begin
      errors++;
      $display("FAIL done_once: got %0d expected 1", done_hits);
    end
  endtask

  task automatic test_abort();
    @(negedge clock);
    done_hits = 0;
    pattern = 4'b1011; repeat_count = 4'd1; gap = 4'd0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
    end
    checks++;
    if (seq_valid !== 1'b1 || seq_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort_bit2: valid/out got %b%b expected 11", seq_valid, seq_out);
    end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    checks++;
    if ({seq_valid, busy, seq_out, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort: valid/busy/out/done got %b%b%b%b expected 0000",
               seq_valid, busy, seq_out, done);
    end
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (done_hits !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses expected 0", done_hits);
    end
    @(negedge clock);
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || seq_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_over_start: busy/valid got %b%b expected 00", busy, seq_valid);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    pattern = 4'b1010; repeat_count = 4'd2; gap = 4'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1 || seq_valid !== 1'b0) begin
      errors++;
      $display("FAIL in_gap: busy/valid got %b%b expected 10", busy, seq_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, seq_out, seq_valid, done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: busy/out/valid/done got %b%b%b%b expected 0000",
               busy, seq_out, seq_valid, done);
    end
    @(negedge clock);
    reset = 1'b0;
    run_tx(4'b1001, 1, 0, 1'b0, "post_reset_1001");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      run_tx(4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b1,
             "random");
    run_tx(4'($urandom), 15, 1, 1'b1, "repeat_all_ones");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_repeat_zero();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
